// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store to req/ack bus unit; define MISALIGN_TRAP_EN to trap misaligned accesses via a misalign port
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          ld_en,
  input  logic [2:0]    ld_type,
  input  logic [1:0]    st_type,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic          misalign
`endif
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, ld_q, ld_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [3:0] bus_be_q, bus_be_d, be;
  logic [31:0] bus_wdata_q, bus_wdata_d, rsp_rdata_q, rsp_rdata_d, wd, ext;
  logic [2:0] ld_type_q, ld_type_d;
  logic [1:0] lane_q, lane_d;
  logic [15:0] half;
  logic [7:0] b8;
  logic is_st, memop, accept, misaligned, timeout;
`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign misalign = mis_q;
`endif
  assign req_ready = state_q == IDLE;
  assign stall = (state_q == IDLE && req_valid && memop) || state_q == BUS;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign bus_req = bus_req_q;
  assign bus_we = bus_we_q;
  assign bus_addr = bus_addr_q;
  assign bus_be = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  always_comb begin
    is_st = st_type != 2'b00;
    memop = ld_en | is_st;
    accept = req_valid && memop && state_q == IDLE;
    be = st_type == 2'b10 ? 4'b0001 << addr[1:0] : st_type == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = st_type == 2'b10 ? {4{wdata[7:0]}} : st_type == 2'b01 ? {2{wdata[15:0]}} : is_st ? wdata : 32'h0;
`ifdef MISALIGN_TRAP_EN
    misaligned = is_st ? ((st_type == 2'b01 && addr[0]) || (st_type == 2'b11 && addr[1:0] != 2'b00))
                       : ((ld_type == 3'b000 && addr[1:0] != 2'b00) || ((ld_type == 3'b001 || ld_type == 3'b010) && addr[0]));
`else
    misaligned = 1'b0;
`endif
    b8 = lane_q[1] ? (lane_q[0] ? bus_rdata[31:24] : bus_rdata[23:16]) : (lane_q[0] ? bus_rdata[15:8] : bus_rdata[7:0]);
    half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ext = ld_type_q == 3'b001 ? {{16{half[15]}}, half} :
          ld_type_q == 3'b010 ? {16'h0, half} :
          ld_type_q == 3'b011 ? {{24{b8[7]}}, b8} :
          ld_type_q == 3'b100 ? {24'h0, b8} : bus_rdata;
    timeout = TIMEOUT_CYCLES != 0 && cnt_q + 1'b1 == TMAX;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bus_req_d = bus_req_q;
    bus_we_d = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_be_d = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ld_d = ld_q;
    ld_type_d = ld_type_q;
    lane_d = lane_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (accept) begin
        ld_d = ~is_st;
        ld_type_d = ld_type;
        lane_d = addr[1:0];
        bus_we_d = is_st;
        bus_addr_d = {addr[AW-1:2], 2'b00};
        bus_be_d = be;
        bus_wdata_d = wd;
        cnt_d = '0;
        if (misaligned) begin
          state_d = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
          mis_d = 1'b1;
`endif
        end else begin
          state_d = BUS;
          bus_req_d = 1'b1;
        end
      end
      BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_ack || timeout) begin
          state_d = RESP;
          bus_req_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d = ~bus_ack;
          rsp_rdata_d = bus_ack && ld_q ? ext : 32'h0;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bus_req_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_addr_q <= '0;
      bus_be_q <= 4'h0;
      bus_wdata_q <= 32'h0;
      ld_q <= 1'b0;
      ld_type_q <= 3'h0;
      lane_q <= 2'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bus_req_q <= bus_req_d;
      bus_we_q <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_be_q <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      ld_q <= ld_d;
      ld_type_q <= ld_type_d;
      lane_q <= lane_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
`ifdef MISALIGN_TRAP_EN
      mis_q <= mis_d;
`endif
    end
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit; the consuming end of the decoder's MemRead/MemWrite/MemtoReg encodings.
- Turns a decoded load/store into a single req/ack bus transaction with byte enables, then returns extended load data and a pipeline stall.
- Sits between the EX/MEM pipeline register and the data RAM bus.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for bus_ack before abort; 0 = wait forever.
- AW, 32: byte address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM-stage instruction valid
- req_ready  out  1  unit can accept a request
- ld_en  in  1  load instruction (MemtoReg)
- ld_type  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu
- st_type  in  2  00 none, 01 sh, 10 sb, 11 sw
- addr  in  AW  ALU byte address
- wdata  in  32  store data (rt)
- stall  out  1  freeze PC/IF/ID/EX while an access is pending
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data (0 for stores/errors)
- rsp_err  out  1  completion carries timeout or misalign error
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  AW  word-aligned address (addr[1:0] = 00)
- bus_be  out  4  byte enables, bit i = byte lane i
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion; rdata valid the same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset: state IDLE; every registered output 0 (bus_req, bus_we, bus_addr, bus_be, bus_wdata, rsp_valid, rsp_rdata, rsp_err, counter). req_ready = 1 and stall = 0 immediately.
- Memory op: memop = ld_en | (st_type != 00). If st_type != 00 the store wins and ld_en is ignored.
- Accept: req_valid & req_ready & memop. Non-memop requests are ignored, with no stall and no response.
- States:
  - IDLE: req_ready = 1. On accept, latch the request and drive the bus outputs; go BUS, or RESP when misaligned under the optional feature.
  - BUS: bus_req = 1, with all bus outputs stable. On bus_ack, capture bus_rdata and go RESP. If the counter reaches TIMEOUT_CYCLES (nonzero) without ack, drop bus_req, set rsp_err, go RESP.
  - RESP: rsp_valid = 1 for exactly one cycle; bus_req = 0; go IDLE.
- stall = (IDLE & req_valid & memop) | BUS. Stall is 0 in RESP, so the pipeline advances on the rsp_valid cycle.
- Minimum latency: accept at cycle 0, BUS at 1 with ack, rsp_valid at 2.
- Little-endian byte lanes, lane = addr[1:0]:
  - sb: be = 1 << lane; wdata = {4{wdata[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - sw: be = 1111.
  - Loads: be = 1111, bus_we = 0.
- Load extraction from the captured word:
  - lb/lbu: byte at lane, sign- or zero-extended.
  - lh/lhu: half selected by addr[1], sign- or zero-extended.
  - lw: whole word.
- rsp_rdata = 0 for stores and on rsp_err.
- bus_ack outside BUS is ignored. An ack arriving in the same cycle the timeout is reached counts as success.
- Reset mid-transaction (any state): return immediately to IDLE with bus_req = 0; the lost access is not replayed.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means halfword with addr[0] = 1, or word with addr[1:0] != 00.
  - A misaligned request skips BUS and issues no bus_req. RESP asserts rsp_err = 1 with rsp_rdata = 0.
  - Extra output port misalign (1 bit) pulses together with that rsp_valid.
- Undefined:
  - No check and no misalign port.
  - Halfword ignores addr[0]; word ignores addr[1:0].

Test Plan:
- sb, addr = 0x1003, wdata = 0x000000AB, immediate ack -> bus_be = 1000, bus_wdata = 0xABABABAB, bus_addr = 0x1000, rsp_valid at cycle 2, stall high on cycles 0-1.
- lb then lbu, addr = 0x2002, bus_rdata = 0x12F45678 -> rsp_rdata = 0xFFFFFFF4, then 0x000000F4.
- lh, addr = 0x2002, bus_rdata = 0x80011234, ack delayed 5 cycles -> bus outputs stable throughout, rsp_rdata = 0xFFFF8001, rsp_valid 6 cycles after BUS entry.
- sw with no ack, TIMEOUT_CYCLES = 4 -> bus_req drops after 4 BUS cycles, rsp_valid with rsp_err = 1, unit returns to IDLE.
- MISALIGN_TRAP_EN defined: lw, addr = 0x3001 -> no bus_req, misalign = 1, rsp_err = 1. Undefined: bus_addr = 0x3000, bus_be = 1111.
- rst_n low during BUS -> bus_req = 0 and state IDLE with no clock edge; req_valid with st_type = 00 and ld_en = 0 -> no stall, no bus activity.
